// File: rtl/rs_key_conditioner_if.sv
// rs_key_conditioner_if: raw keys in, latch pulses and debounced levels out.
interface rs_key_conditioner_if;
    logic KeySet;
    logic KeyReset;
    logic S;
    logic R;
    logic SetHeld;
    logic ResetHeld;
    logic Conflict;
    modport master (output KeySet, KeyReset, input S, R, SetHeld, ResetHeld, Conflict);
    modport slave (input KeySet, KeyReset, output S, R, SetHeld, ResetHeld, Conflict);
endinterface

// File: rtl/rs_key_conditioner.sv
// rs_key_conditioner: two-key synchronizer/debouncer/press detector feeding
// reset-dominant one-cycle S/R pulses for the RS latch.
module rs_key_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W = 20,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic key_i,
    output logic held_o,
    output logic qual_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic sync1_q, sync2_q, stable_q, stable_d, lvl, hit;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        lvl = sync2_q ^ KEY_ACTIVE_LOW;
        hit = (lvl != stable_q) && (cnt_q == LAST);
        cnt_d = (lvl == stable_q || hit) ? '0 : cnt_q + 1'b1;
        stable_d = hit ? lvl : stable_q;
    end
    // sync FFs hold the raw released level so reset never looks like a press
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q  <= KEY_ACTIVE_LOW;
            sync2_q  <= KEY_ACTIVE_LOW;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
    assign held_o = stable_q;
    assign qual_o = hit & lvl;
endmodule

module rs_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W = 20,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input logic Clk,
    input logic Reset_n,
    rs_key_conditioner_if.slave bus
);
    logic qual_set, qual_reset, s_q, r_q, conflict_q, s_d, r_d, conflict_d;
    rs_key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_set (
        .Clk(Clk), .Reset_n(Reset_n), .key_i(bus.KeySet), .held_o(bus.SetHeld), .qual_o(qual_set)
    );
    rs_key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_reset (
        .Clk(Clk), .Reset_n(Reset_n), .key_i(bus.KeyReset), .held_o(bus.ResetHeld), .qual_o(qual_reset)
    );
    // reset key wins when both presses qualify together
    always_comb begin
        r_d = qual_reset;
        s_d = qual_set & ~qual_reset;
        conflict_d = qual_set & qual_reset;
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end
    assign bus.S = s_q;
    assign bus.R = r_q;
    assign bus.Conflict = conflict_q;
endmodule

// File: tb/tb_rs_key_conditioner.sv
// tb_rs_key_conditioner: directed scenarios plus random key activity against a
// history-based model of the debounced keys (DEBOUNCE_CYCLES=4, active-low keys).
module tb_rs_key_conditioner;
    localparam int D = 4;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int total = 0;
    int passed = 0;
    bit p1[2], p2[2], stable[2];
    bit [31:0] miss[2];
    bit e_s, e_r, e_c;

    rs_key_conditioner_if bus ();
    rs_key_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .KEY_ACTIVE_LOW(1'b1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave)
    );

    always #10 Clk = ~Clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        chk("S", bus.S, e_s);
        chk("R", bus.R, e_r);
        chk("Conflict", bus.Conflict, e_c);
        chk("SetHeld", bus.SetHeld, stable[0]);
        chk("ResetHeld", bus.ResetHeld, stable[1]);
        chk("S_and_R_exclusive", bus.S & bus.R, 1'b0);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            p1[c] = 1'b1;
            p2[c] = 1'b1;
            stable[c] = 1'b0;
            miss[c] = '0;
        end
        {e_s, e_r, e_c} = '0;
    endtask

    // press level seen after a 2-sample delay; the debounced level flips once the
    // last D samples since the previous flip all disagree with it
    function automatic bit model_edge(input int c, input bit raw);
        bit lvl, q;
        lvl = ~p2[c];
        p2[c] = p1[c];
        p1[c] = raw;
        miss[c] = {miss[c][30:0], lvl != stable[c]};
        q = 1'b0;
        if (miss[c][D-1:0] == {D{1'b1}}) begin
            q = lvl;
            stable[c] = lvl;
            miss[c] = '0;
        end
        return q;
    endfunction

    task automatic tick();
        bit qs, qr;
        if (Reset_n) begin
            qs = model_edge(0, bus.KeySet);
            qr = model_edge(1, bus.KeyReset);
            e_s = qs & ~qr;
            e_r = qr;
            e_c = qs & qr;
        end
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic assert_reset();
        Reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask

    initial begin
        bus.KeySet = 1'b1;
        bus.KeyReset = 1'b1;
        model_reset();
        #1;
        check_all();
        ticks(2);
        Reset_n = 1'b1;
        // 1: idle keys
        ticks(20);
        chk("idle_SetHeld", bus.SetHeld, 1'b0);
        // 2: set press, pulse on the 6th edge, no repeat while held
        bus.KeySet = 1'b0;
        ticks(5);
        chk("press_S_early", bus.S, 1'b0);
        tick();
        chk("press_S_edge6", bus.S, 1'b1);
        chk("press_SetHeld", bus.SetHeld, 1'b1);
        tick();
        chk("press_S_one_cycle", bus.S, 1'b0);
        ticks(15);
        bus.KeySet = 1'b1;
        ticks(6);
        chk("release_SetHeld", bus.SetHeld, 1'b0);
        ticks(4);
        // 3: bounce every 2 cycles
        for (int i = 0; i < 15; i++) begin
            bus.KeySet = ~bus.KeySet;
            ticks(2);
        end
        bus.KeySet = 1'b1;
        ticks(10);
        chk("bounce_SetHeld", bus.SetHeld, 1'b0);
        // 4: simultaneous press
        bus.KeySet = 1'b0;
        bus.KeyReset = 1'b0;
        ticks(6);
        chk("both_R", bus.R, 1'b1);
        chk("both_Conflict", bus.Conflict, 1'b1);
        chk("both_S", bus.S, 1'b0);
        ticks(3);
        bus.KeySet = 1'b1;
        bus.KeyReset = 1'b1;
        ticks(10);
        // 5: reset mid-count with key held through release
        bus.KeyReset = 1'b0;
        ticks(5);
        assert_reset();
        ticks(3);
        Reset_n = 1'b1;
        ticks(5);
        chk("rst_R_early", bus.R, 1'b0);
        tick();
        chk("rst_R_edge6", bus.R, 1'b1);
        bus.KeyReset = 1'b1;
        ticks(10);
        // 6: set held, reset pressed, release both
        bus.KeySet = 1'b0;
        ticks(10);
        bus.KeyReset = 1'b0;
        ticks(6);
        chk("held_R", bus.R, 1'b1);
        chk("held_SetHeld", bus.SetHeld, 1'b1);
        bus.KeySet = 1'b1;
        bus.KeyReset = 1'b1;
        ticks(5);
        chk("rel_SetHeld_early", bus.SetHeld, 1'b1);
        tick();
        chk("rel_SetHeld", bus.SetHeld, 1'b0);
        chk("rel_ResetHeld", bus.ResetHeld, 1'b0);
        ticks(4);
        // random key activity with occasional resets
        for (int i = 0; i < 120; i++) begin
            bus.KeySet = 1'($urandom_range(0, 1));
            bus.KeyReset = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                assert_reset();
                ticks(1);
                Reset_n = 1'b1;
            end
            ticks($urandom_range(1, 9));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
